fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter for sync_fifo_counter. Shares the single FIFO write
//  port among NUM_REQ producers. Grants bursts of up to BURST_LEN words per owner.
//  Uses the FIFO fcounter for backpressure so the FIFO can never be overwritten.
//  Drives the FIFO w_enable/w_data directly. The FIFO read side is not touched.
// PARAMETERS
//  DATA_WIDTH  8    FIFO word width
//  DATA_DEPTH  512  FIFO depth; must match the FIFO instance
//  NUM_REQ     4    number of producers, >=2
//  BURST_LEN   4    max words accepted per grant, >=1
// PORTS
//  clk        in   1                         system clock
//  reset      in   1                         async active-low reset
//  req        in   NUM_REQ                   producer i has a word on req_data[i]
//  req_data   in   NUM_REQ*DATA_WIDTH        packed producer data; slice i = [i*DW +: DW]
//  grant      out  NUM_REQ                   one-hot, combinational; word accepted this cycle
//  fifo_cnt   in   $clog2(DATA_DEPTH)+1      FIFO fcounter
//  w_enable   out  1                         registered FIFO write enable
//  w_data     out  DATA_WIDTH                registered FIFO write data
//  busy       out  1                         FSM in BURST
//  cur_owner  out  $clog2(NUM_REQ)           current/last burst owner
//  accept_total out 32                       only with ARB_STATS_EN
// BEHAVIOUR
//  - Reset (async, reset==0):
//    - FSM=IDLE; w_enable=0; w_data=0; busy=0; cur_owner=0; beat_cnt=0.
//    - last_owner=NUM_REQ-1, so the first grant goes to req[0].
//    - grant is forced to 0 while reset is low.
//  - IDLE: if |req, pick the first set req scanning last_owner+1, +2, ... (mod NUM_REQ).
//    Load cur_owner and beat_cnt=0, then go to BURST.
//    No grant in IDLE; arbitration costs exactly 1 cycle.
//  - Space check: space_ok = (fifo_cnt + w_enable) < DATA_DEPTH.
//    The in-flight write counts; concurrent FIFO reads are ignored (conservative).
//  - BURST: accept = req[cur_owner] & space_ok; grant[cur_owner]=accept, other bits 0.
//  - On accept:
//    - w_data <= req_data[cur_owner] and w_enable <= 1 on the next edge.
//    - The word reaches the FIFO 1 cycle after grant.
//    - Otherwise w_enable <= 0 and w_data holds its value.
//  - BURST exit to IDLE, with last_owner <= cur_owner:
//    - (a) accept while beat_cnt==BURST_LEN-1, or
//    - (b) req[cur_owner]==0.
//    - Else beat_cnt += accept and stay in BURST.
//  - FIFO full (space_ok==0) with req held: stay in BURST, owner kept, no timeout, no grant.
//  - Producer protocol: hold req_data stable while req=1. A word is consumed only in a grant
//    cycle; the producer advances its data only after a grant.
//  - Simultaneous requests are never granted in the same cycle; strict rotation prevents
//    starvation.
//  - Reset mid-burst aborts the burst immediately:
//    - w_enable drops asynchronously.
//    - No partial word is written after reset deasserts.
//  - Width: fifo_cnt + w_enable is evaluated at $clog2(DATA_DEPTH)+2 bits. No wrap.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    - Adds port accept_total (32b), reset 0, +1 on every accept.
//    - Wraps 2^32-1 -> 0.
//  ARB_STATS_EN undefined:
//    - Port and counter are absent; all other behaviour is identical.
// TESTING
//  1 Hold reset low, req=4'b1111 -> grant=0, w_enable=0, busy=0, cur_owner=0.
//    Release reset -> first grant=4'b0001 two cycles later.
//  2 req=4'b1111 held, FIFO draining, BURST_LEN=4 -> grants 0x4, gap, 1x4, gap, 2x4, gap,
//    3x4, gap, 0x4; w_enable pattern 4 on, 1 off.
//  3 req=4'b0001 held, no FIFO reads -> exactly 512 writes, fcounter=512, full=1.
//    No grant once fifo_cnt+w_enable==512. Read 1 word -> exactly one more grant.
//  4 req0 drops after 2 words, req2 pending -> IDLE 1 cycle, then cur_owner=2, grant=4'b0100.
//  5 reset low during beat 2 of an owner-1 burst -> w_enable=0 immediately.
//    After release, cur_owner=0 and the first grant goes to req0.
//  6 ARB_STATS_EN, 10 accepted words -> accept_total=10. Reset -> accept_total=0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between the producers, the arbiter and the FIFO write port.
// slave  : arbiter view (takes requests and FIFO fill level, drives grant and write port)
// master : environment view (producers plus FIFO)
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 512,
   parameter int NUM_REQ    = 4
);
   localparam int CNT_W = $clog2(DATA_DEPTH) + 1;

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            grant;
   logic [CNT_W-1:0]              fifo_cnt;
   logic                          w_enable;
   logic [DATA_WIDTH-1:0]         w_data;

   modport slave (
      input  req,
      input  req_data,
      input  fifo_cnt,
      output grant,
      output w_enable,
      output w_data
   );

   modport master (
      output req,
      output req_data,
      output fifo_cnt,
      input  grant,
      input  w_enable,
      input  w_data
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each owner gets a burst of up to BURST_LEN words; the FIFO fill level plus
// the in-flight write gates every grant so the FIFO cannot be overrun.
// Optional feature: define ARB_STATS_EN to add the 32-bit accept_total counter.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no owner; picks the next requester after last_owner
// BURST  | cur_owner may write; one grant per cycle while space allows
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 512,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 4,
   localparam int OWN_W     = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   fifo_wr_arbiter_if.slave bus,
   output logic             busy,
   output logic [OWN_W-1:0] cur_owner
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]      accept_total
`endif
);

   localparam int CNT_W     = $clog2(DATA_DEPTH) + 1;
   localparam int SUM_W     = CNT_W + 1;
   localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
   localparam logic [OWN_W-1:0]  OWNER_LAST = OWN_W'(NUM_REQ - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [OWN_W-1:0]        cur_owner_q, cur_owner_d;
   logic [OWN_W-1:0]        last_owner_q, last_owner_d;
   logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic                    w_enable_q, w_enable_d;
   logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
`ifdef ARB_STATS_EN
   logic [31:0]             accept_total_q, accept_total_d;
`endif

   logic [SUM_W-1:0]        cnt_sum;
   logic                    space_ok;
   logic                    sel_req;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    accept;
   logic [NUM_REQ-1:0]      grant_v;
   logic                    rr_found;
   logic [OWN_W-1:0]        rr_pick;
   int                      rr_dist;
   int                      rr_best;

   // Free-space check; the write already in flight is counted, pending reads are not
   always_comb begin
      cnt_sum  = {1'b0, bus.fifo_cnt} + {{CNT_W{1'b0}}, w_enable_q};
      space_ok = (cnt_sum < SUM_W'(DATA_DEPTH));
   end

   // Current owner's request and data
   always_comb begin
      sel_req  = 1'b0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cur_owner_q == OWN_W'(i)) begin
            sel_req  = bus.req[i];
            sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Round-robin pick: nearest requester strictly after last_owner (wrapping)
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = '0;
      rr_dist  = 0;
      rr_best  = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i > int'(last_owner_q))
            rr_dist = i - int'(last_owner_q) - 1;
         else
            rr_dist = i + NUM_REQ - int'(last_owner_q) - 1;
         if (bus.req[i] && (rr_dist < rr_best)) begin
            rr_best  = rr_dist;
            rr_pick  = OWN_W'(i);
            rr_found = 1'b1;
         end
      end
   end

   // Accept and one-hot grant; grant is held low while reset is asserted
   always_comb begin
      accept  = (state_q == S_BURST) && sel_req && space_ok;
      grant_v = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_v[i] = accept && (cur_owner_q == OWN_W'(i));
      end
   end

   assign bus.grant    = reset ? grant_v : '0;
   assign bus.w_enable = w_enable_q;
   assign bus.w_data   = w_data_q;
   assign busy         = (state_q == S_BURST);
   assign cur_owner    = cur_owner_q;
`ifdef ARB_STATS_EN
   assign accept_total = accept_total_q;
`endif

   // Next-state, burst bookkeeping and write-port staging
   always_comb begin
      state_d      = state_q;
      cur_owner_d  = cur_owner_q;
      last_owner_d = last_owner_q;
      beat_cnt_d   = beat_cnt_q;
      w_enable_d   = 1'b0;
      w_data_d     = w_data_q;
`ifdef ARB_STATS_EN
      accept_total_d = accept_total_q + {31'd0, accept};
`endif
      case (state_q)
         S_IDLE: begin
            if (rr_found) begin
               cur_owner_d = rr_pick;
               beat_cnt_d  = '0;
               state_d     = S_BURST;
            end
         end
         S_BURST: begin
            if (accept) begin
               w_enable_d = 1'b1;
               w_data_d   = sel_data;
            end
            // A full FIFO with the request still held just waits here
            if ((accept && (beat_cnt_q == BEAT_LAST)) || !sel_req) begin
               state_d      = S_IDLE;
               last_owner_d = cur_owner_q;
            end else if (accept) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops w_enable at once, aborting any burst
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cur_owner_q  <= '0;
         last_owner_q <= OWNER_LAST;
         beat_cnt_q   <= '0;
         w_enable_q   <= 1'b0;
         w_data_q     <= '0;
`ifdef ARB_STATS_EN
         accept_total_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cur_owner_q  <= cur_owner_d;
         last_owner_q <= last_owner_d;
         beat_cnt_q   <= beat_cnt_d;
         w_enable_q   <= w_enable_d;
         w_data_q     <= w_data_d;
`ifdef ARB_STATS_EN
         accept_total_q <= accept_total_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural FIFO fill counter and
// a write-data scoreboard (word pushed at grant, popped when w_enable shows it).
module tb_fifo_wr_arbiter;
   localparam int DW    = 8;
   localparam int DEPTH = 512;
   localparam int NR    = 4;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic [NR-1:0] req   = '0;
   logic          rd_en = 1'b0;
   logic [9:0]    fifo_cnt;
   logic          busy;
   logic [1:0]    cur_owner;
`ifdef ARB_STATS_EN
   logic [31:0]   accept_total;
`endif

   logic [DW-1:0] pdata [NR];
   logic [DW-1:0] exp_q [$];
   int            n_pass  = 0;
   int            n_total = 0;
   int            acc_cnt = 0;

   logic [NR-1:0] s_grant;
   logic          s_busy;
   logic          s_we;
   logic [1:0]    s_owner;

   fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .NUM_REQ(NR)) bus ();

   assign bus.req      = req;
   assign bus.fifo_cnt = fifo_cnt;

   always_comb begin
      bus.req_data = '0;
      for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = pdata[i];
   end

   fifo_wr_arbiter #(
      .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .NUM_REQ(NR), .BURST_LEN(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .busy      (busy),
      .cur_owner (cur_owner)
`ifdef ARB_STATS_EN
      ,
      .accept_total (accept_total)
`endif
   );

   always #5 clk = ~clk;

   // FIFO fill level: write from w_enable, read when asked and not empty
   always @(posedge clk or negedge reset) begin
      if (!reset) fifo_cnt <= '0;
      else fifo_cnt <= fifo_cnt + 10'(bus.w_enable) - 10'(rd_en && (fifo_cnt != 0));
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: sample mid-cycle, score, then return just after the edge
   task automatic cycle();
      logic [DW-1:0] d;
      logic [NR-1:0] adv;
      @(negedge clk);
      s_grant = bus.grant;
      s_busy  = busy;
      s_owner = cur_owner;
      s_we    = bus.w_enable;
      check("w_enable_vs_scoreboard", {31'd0, s_we}, {31'd0, exp_q.size() != 0});
      if (s_we && exp_q.size() != 0) begin
         d = exp_q.pop_front();
         check("w_data", {24'd0, bus.w_data}, {24'd0, d});
      end
      check("no_overflow", {31'd0, s_we && (fifo_cnt >= 10'(DEPTH)) && !rd_en}, 32'd0);
      check("grant_onehot0", {31'd0, $onehot0(s_grant)}, 32'd1);
      check("grant_within_req", {28'd0, s_grant & ~req}, 32'd0);
      adv = s_grant;
      for (int i = 0; i < NR; i++) begin
         if (s_grant[i]) begin
            exp_q.push_back(pdata[i]);
            acc_cnt++;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (adv[i]) pdata[i] = pdata[i] + 8'd1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      exp_q.delete();
      acc_cnt = 0;
      cycle();
      cycle();
      reset = 1'b1;
   endtask

   initial begin
      int gcnt;
      logic [NR-1:0] exp_g;
      for (int i = 0; i < NR; i++) pdata[i] = 8'(i * 64 + 1);
      #2;

      // 1: reset held with all requests
      reset = 1'b0;
      req   = 4'b1111;
      rd_en = 1'b1;
      cycle();
      cycle();
      cycle();
      check("t1_rst_grant", {28'd0, s_grant}, 32'd0);
      check("t1_rst_we", {31'd0, s_we}, 32'd0);
      check("t1_rst_busy", {31'd0, s_busy}, 32'd0);
      check("t1_rst_owner", {30'd0, s_owner}, 32'd0);
      reset = 1'b1;
      cycle();
      check("t1_arb_gap", {28'd0, s_grant}, 32'd0);

      // 2: full rotation with draining FIFO
      for (int k = 0; k < 25; k++) begin
         cycle();
         exp_g = (k % 5 == 4) ? 4'b0000 : 4'(1 << ((k / 5) % 4));
         check("t2_grant", {28'd0, s_grant}, {28'd0, exp_g});
         check("t2_busy", {31'd0, s_busy}, {31'd0, k % 5 != 4});
      end

      // 3: single producer fills the FIFO, then one read frees one slot
      req   = 4'b0001;
      rd_en = 1'b0;
      do_reset();
      gcnt = 0;
      for (int k = 0; k < 1200; k++) begin
         cycle();
         if (s_grant != 0) gcnt++;
      end
      check("t3_grants", gcnt, 512);
      check("t3_fifo_cnt", {22'd0, fifo_cnt}, 32'd512);
      check("t3_stall_busy", {31'd0, s_busy}, 32'd1);
      check("t3_stall_owner", {30'd0, s_owner}, 32'd0);
      rd_en = 1'b1;
      cycle();
      gcnt = (s_grant != 0) ? 1 : 0;
      rd_en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (s_grant != 0) gcnt++;
      end
      check("t3_one_more", gcnt, 1);
      check("t3_fifo_cnt_after", {22'd0, fifo_cnt}, 32'd512);

      // 4: owner drops request early, next requester takes over
      req   = 4'b0101;
      rd_en = 1'b1;
      do_reset();
      cycle();
      check("t4_arb", {28'd0, s_grant}, 32'd0);
      cycle();
      check("t4_w0", {28'd0, s_grant}, 32'd1);
      cycle();
      check("t4_w1", {28'd0, s_grant}, 32'd1);
      req = 4'b0100;
      cycle();
      check("t4_drop_grant", {28'd0, s_grant}, 32'd0);
      check("t4_drop_busy", {31'd0, s_busy}, 32'd1);
      cycle();
      check("t4_idle_grant", {28'd0, s_grant}, 32'd0);
      check("t4_idle_busy", {31'd0, s_busy}, 32'd0);
      cycle();
      check("t4_next_grant", {28'd0, s_grant}, 32'h4);
      check("t4_next_owner", {30'd0, s_owner}, 32'd2);

      // 5: reset during beat 2 of an owner-1 burst
      req = 4'b0010;
      do_reset();
      cycle();
      check("t5_arb", {28'd0, s_grant}, 32'd0);
      cycle();
      check("t5_b0", {28'd0, s_grant}, 32'h2);
      cycle();
      check("t5_b1", {28'd0, s_grant}, 32'h2);
      check("t5_we_inflight", {31'd0, bus.w_enable}, 32'd1);
      reset = 1'b0;
      #1;
      check("t5_we_async", {31'd0, bus.w_enable}, 32'd0);
      check("t5_grant_rst", {28'd0, bus.grant}, 32'd0);
      check("t5_busy_rst", {31'd0, busy}, 32'd0);
      check("t5_owner_rst", {30'd0, cur_owner}, 32'd0);
      exp_q.delete();
      req = 4'b0011;
      cycle();
      reset = 1'b1;
      cycle();
      check("t5_rel_gap", {28'd0, s_grant}, 32'd0);
      check("t5_rel_owner", {30'd0, s_owner}, 32'd0);
      cycle();
      check("t5_rel_grant", {28'd0, s_grant}, 32'd1);

`ifdef ARB_STATS_EN
      // 6: accept counter
      req = 4'b0001;
      do_reset();
      for (int k = 0; k < 100 && acc_cnt < 10; k++) cycle();
      req = 4'b0000;
      cycle();
      cycle();
      check("t6_acc_seen", acc_cnt, 10);
      check("t6_accept_total", accept_total, 32'd10);
      reset = 1'b0;
      #1;
      check("t6_accept_total_rst", accept_total, 32'd0);
      exp_q.delete();
      cycle();
      reset = 1'b1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
